seven_seg_scan: RTL
===================

# seven_seg_scan

Time-multiplexing scheduler for the 4-digit seven-segment display. Owns the single shared `seven_decoder` instance and drives its `sel`, `number` and `en` inputs, cycling through the four digits at a programmable refresh rate. Between digits it inserts a blanking interval to suppress ghosting. Software-facing digit data is double-buffered and committed only at frame boundaries, so a frame never shows a mix of old and new digits.

## Interface
Parameters:
- `DIV`, 100000: clock cycles per digit slot. Must satisfy `DIV >= DEAD + 2`.
- `DEAD`, 1000: blanking cycles at the start of each slot, during which `en` is forced to 0.

Ports:
- `clk` input 1: system clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `scan_en` input 1: scanning enable. When low, the display is blanked and the counters are held at 0.
- `load_valid` input 1: the new digit set on `ld_num`/`ld_en` is valid.
- `load_ready` output 1: the pending buffer is empty and can accept a load.
- `ld_num` input 32: digit values, 8 bits per digit. Digit 0 is `[7:0]`.
- `ld_en` input 8: per-digit mode, 2 bits per digit. 0 = off, 1 = decimal, 3 = raw segments, 2 = off.
- `sel` output 2: digit select to the decoder.
- `number` output 8: value for the selected digit.
- `en` output 2: mode for the selected digit, or 0 while blanked.
- `frame_done` output 1: one-cycle pulse at the end of digit 3's slot.

## Operation
- Registers:
  - `pend_num`/`pend_en` plus a `pend_full` flag (the pending buffer).
  - `act_num`/`act_en` (the active set).
  - slot counter `cnt` (range 0..DIV-1).
  - digit index `dig` (range 0..3).
- Load handshake:
  - A transfer occurs when `load_valid && load_ready`, with `load_ready = !pend_full`.
  - A transfer captures the inputs into the pending buffer and sets `pend_full`.
  - `load_valid` may be held; only the first accepted beat is taken until the buffer drains.
- Commit:
  - At a frame boundary (`cnt==DIV-1 && dig==3`), if `pend_full` is set: active ← pending and `pend_full` clears.
  - A load accepted in the boundary cycle itself lands in pending, because the buffer was empty. It commits at the next boundary.
  - While `scan_en`=0, a pending set commits on the cycle after it is accepted.
- FSM, 3 states:
  - OFF: `scan_en`=0. Outputs `sel`=0, `en`=0; `cnt`=0, `dig`=0. Goes to BLANK when `scan_en` rises.
  - BLANK: `cnt` < DEAD. `sel`=`dig`, `number`=act_num[dig], `en`=0. Goes to SHOW at `cnt`==DEAD-1.
  - SHOW: `cnt` ≥ DEAD. `en`=act_en[dig]. At `cnt`==DIV-1: `cnt`←0, `dig`←`dig`+1 (wraps 3→0), state←BLANK.
  - Any state goes to OFF within one cycle when `scan_en` falls. An in-flight slot is abandoned and the next scan restarts at digit 0.
- Arithmetic:
  - `cnt` width is `$clog2(DIV)`.
  - `dig` is a 2-bit counter that wraps naturally.
  - Mode 2 is passed through unchanged; the decoder treats it as off.

## Timing
- All outputs are registered, with a 1-cycle latency from state to pins.
- Reset values: `sel`=0, `number`=0, `en`=0, `load_ready`=1, `frame_done`=0. Active and pending sets are 0, which is all digits off. State is OFF.
- `rst_n` asserted mid-frame clears everything asynchronously, including any pending load.
- `frame_done` is asserted in the cycle after the boundary, together with the first cycle of digit 0's BLANK slot showing the newly committed set.
- One frame is 4·DIV cycles.

## Configuration
- `SEVSEG_BRIGHTNESS_EN`:
  - Defined:
    - Adds input `brightness` [3:0], sampled at each frame boundary.
    - A 4-bit PWM counter increments every cycle in SHOW.
    - `en` is forced to 0 when pwm_cnt ≥ brightness. 0 means dark; 15 means a 15/16 duty cycle.
  - Undefined:
    - No `brightness` port.
    - SHOW always drives full duty.

## Structure
- Package `seven_seg_pkg` holds:
  - `NUM_DIGITS`=4.
  - Mode constants `EN_OFF`=2'd0, `EN_DEC`=2'd1, `EN_RAW`=2'd3.
  - The FSM state enum (OFF, BLANK, SHOW).
- Sub-module `seven_seg_pwm` (counter and compare) is instantiated only under `SEVSEG_BRIGHTNESS_EN`.

## Test plan
All scenarios use `DIV`=4 and `DEAD`=1.
- Reset, then `scan_en`=1 with no load → `en`=0 on every cycle, `sel` sequence 0,0,0,0,1,1,1,1,2…, `load_ready`=1.
- Load `ld_num`=0x03020100, `ld_en`=0x55 while `scan_en`=0, then enable → per slot: 1 cycle with `en`=0, then 3 cycles with `en`=1 and `number`=`sel`. `frame_done` pulses every 16 cycles.
- Mid-frame load of 0x09090909 → `load_ready` drops to 0. Digits keep their old values until `frame_done`, then all show 9. `load_ready` returns to 1 in the same cycle.
- Load accepted exactly in the boundary cycle → it is not displayed for one frame and appears after the following `frame_done`.
- Drop `scan_en` at `sel`=2 during SHOW → next cycle `en`=0 and `sel`=0. On re-enable, scanning restarts at digit 0.
- With `SEVSEG_BRIGHTNESS_EN` and `brightness`=4 (use `DIV`=34) → `en`≠0 on exactly 4 of every 16 SHOW cycles.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared constants and FSM state type for the seven-segment scan block.
// Digit count, per-digit mode codes and scan states.
package seven_seg_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [1:0] EN_OFF = 2'd0;
  localparam logic [1:0] EN_DEC = 2'd1;
  localparam logic [1:0] EN_RAW = 2'd3;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

endpackage

// File: rtl/seven_seg_pwm.sv
// Brightness PWM: free-running 4-bit counter over SHOW cycles.
// on is high while the counter is below the requested level.
module seven_seg_pwm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step,
  input  logic       clear,
  input  logic [3:0] level,
  output logic       on
);

  logic [3:0] pcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else if (clear) begin
      pcnt <= '0;
    end else if (step) begin
      pcnt <= pcnt + 1'b1;
    end
  end

  assign on = (pcnt < level);

endmodule

// File: rtl/seven_seg_scan.sv
// Four-digit display scanner with blanking and frame-synchronous reload.
// Optional brightness PWM enabled by SEVSEG_BRIGHTNESS_EN.
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int DIV  = 100000,
  parameter int DEAD = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef SEVSEG_BRIGHTNESS_EN
  input  logic [3:0]  brightness,
`endif
  input  logic        scan_en,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] ld_num,
  input  logic [7:0]  ld_en,
  output logic [1:0]  sel,
  output logic [7:0]  number,
  output logic [1:0]  en,
  output logic        frame_done
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD - 1);
  localparam logic [1:0] DIG_LAST = 2'(NUM_DIGITS - 1);

  state_t        st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    dig, dig_n;
  logic [31:0]   act_num, act_num_n, pend_num;
  logic [7:0]    act_en, act_en_n, pend_en;
  logic          pend_full;
  logic          accept, commit, boundary, gate;

  assign load_ready = !pend_full;
  assign accept     = load_valid && !pend_full;
  assign boundary   = (st == ST_SHOW) && (cnt == CNT_LAST)
                   && (dig == DIG_LAST);
  assign commit     = pend_full
                   && (boundary || st == ST_OFF || !scan_en);
  assign act_num_n  = commit ? pend_num : act_num;
  assign act_en_n   = commit ? pend_en : act_en;

  always_comb begin
    st_n  = st;
    cnt_n = cnt;
    dig_n = dig;
    if (!scan_en) begin
      st_n  = ST_OFF;
      cnt_n = '0;
      dig_n = '0;
    end else begin
      unique case (st)
        ST_OFF: begin
          st_n  = ST_BLANK;
          cnt_n = '0;
          dig_n = '0;
        end
        ST_BLANK: begin
          cnt_n = cnt + 1'b1;
          if (cnt == CNT_DEAD) st_n = ST_SHOW;
        end
        ST_SHOW: begin
          if (cnt == CNT_LAST) begin
            cnt_n = '0;
            dig_n = dig + 1'b1;
            st_n  = ST_BLANK;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: st_n = ST_OFF;
      endcase
    end
  end

`ifdef SEVSEG_BRIGHTNESS_EN
  logic [3:0] bright_q;

  // Level is only picked up between frames so a frame has uniform duty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bright_q <= '0;
    end else if (boundary || st == ST_OFF) begin
      bright_q <= brightness;
    end
  end

  seven_seg_pwm u_pwm (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (st_n == ST_SHOW),
    .clear (st_n == ST_OFF),
    .level (bright_q),
    .on    (gate)
  );
`else
  assign gate = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= ST_OFF;
      cnt       <= '0;
      dig       <= '0;
      act_num   <= '0;
      act_en    <= '0;
      pend_num  <= '0;
      pend_en   <= '0;
      pend_full <= 1'b0;
    end else begin
      st      <= st_n;
      cnt     <= cnt_n;
      dig     <= dig_n;
      act_num <= act_num_n;
      act_en  <= act_en_n;
      if (accept) begin
        pend_num <= ld_num;
        pend_en  <= ld_en;
      end
      pend_full <= (pend_full && !commit) || accept;
    end
  end

  // Pins are loaded from next-state values so they line up with state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel        <= '0;
      number     <= '0;
      en         <= EN_OFF;
      frame_done <= 1'b0;
    end else begin
      sel        <= dig_n;
      number     <= (st_n == ST_OFF) ? 8'd0
                  : act_num_n[{dig_n, 3'b000} +: 8];
      en         <= (st_n == ST_SHOW && gate)
                  ? act_en_n[{dig_n, 1'b0} +: 2] : EN_OFF;
      frame_done <= boundary && scan_en;
    end
  end

endmodule
